vram_scanout: RTL



---
 rtl/vram_scanout_pkg.sv | 28 ++
 rtl/vram_scanout_if.sv | 10 +
 rtl/vram_scanout_timing.sv | 78 +++++++
 rtl/vram_scanout.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vram_scanout_pkg.sv
// Shared types, default 640x480@60 timing and the power-on palette for the
// VRAM scanout engine.
package vram_scanout_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   // Classic CGA colours, index 0 black through index 15 bright white.
   localparam logic [23:0] DEFAULT_PALETTE [16] = '{
      24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
      24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
      24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
      24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
   };

endpackage

// File: rtl/vram_scanout_if.sv
// VRAM video read port: registered read enable/address out, byte data back
// one cycle later.
interface vram_scanout_if #(parameter int ADDR_W = 13);
   logic              mev;
   logic [ADDR_W-1:0] adrv;
   logic [7:0]        qv;

   modport master (output mev, output adrv, input qv);
   modport slave  (input mev, input adrv, output qv);
endinterface

// File: rtl/vram_scanout_timing.sv
// Horizontal/vertical raster counters and the raw (undelayed) sync, active,
// window and frame-boundary flags derived from them.
module video_timing_gen
   import vram_scanout_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit SYNC_POL = 1'b0,
   parameter int X_OFS    = 128,
   parameter int Y_OFS    = 48,
   parameter int WIN_W    = 384,
   parameter int WIN_H    = 384
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_active,
   output logic o_hsync,
   output logic o_vsync,
   output logic o_win,
   output logic o_win_last,
   output logic o_frame_first,
   output logic o_frame_last
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [HW-1:0] X_FIRST  = HW'(X_OFS);
   localparam logic [HW-1:0] X_END    = HW'(X_OFS + WIN_W);
   localparam logic [HW-1:0] X_LAST   = HW'(X_OFS + WIN_W - 1);
   localparam logic [VW-1:0] Y_FIRST  = VW'(Y_OFS);
   localparam logic [VW-1:0] Y_END    = VW'(Y_OFS + WIN_H);

   logic [HW-1:0] r_h;
   logic [VW-1:0] r_v;
   logic          w_hs_on;
   logic          w_vs_on;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_h <= '0;
         r_v <= '0;
      end else if (r_h == H_LAST) begin
         r_h <= '0;
         r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
         r_h <= r_h + 1'b1;
      end
   end

   assign w_hs_on       = (r_h >= HS_START) && (r_h < HS_END);
   assign w_vs_on       = (r_v >= VS_START) && (r_v < VS_END);
   assign o_hsync       = w_hs_on ? SYNC_POL : ~SYNC_POL;
   assign o_vsync       = w_vs_on ? SYNC_POL : ~SYNC_POL;
   assign o_active      = (r_h < H_ACT) && (r_v < V_ACT);
   assign o_win         = o_active && (r_h >= X_FIRST) && (r_h < X_END)
                          && (r_v >= Y_FIRST) && (r_v < Y_END);
   assign o_win_last    = o_win && (r_h == X_LAST);
   assign o_frame_first = (r_h == '0) && (r_v == '0);
   assign o_frame_last  = (r_h == H_LAST) && (r_v == V_LAST);

endmodule

// File: rtl/vram_scanout.sv
// Scanout engine: scaled window fetch from packed-nibble VRAM, palette lookup
// and a 3-stage output pipeline with sync/DE delayed to stay aligned.
module vram_scanout
   import vram_scanout_pkg::*;
#(
   parameter int WIDTH    = 128,
   parameter int HEIGHT   = 128,
   parameter int SCALE    = 3,
   parameter int X_OFS    = 128,
   parameter int Y_OFS    = 48,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit SYNC_POL = 1'b0,
   parameter int ADDR_W   = $clog2((WIDTH * HEIGHT + 1) / 2)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_en,
   vram_scanout_if.master        vram,
   input  logic                  i_pal_we,
   input  logic [3:0]            i_pal_idx,
   input  logic [23:0]           i_pal_rgb,
   output logic                  o_hsync,
   output logic                  o_vsync,
   output logic                  o_de,
   output logic [7:0]            o_r,
   output logic [7:0]            o_g,
   output logic [7:0]            o_b,
   output logic                  o_frame_start
);

   localparam int IDX_W = ADDR_W + 1;
   localparam int SX_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
   localparam logic [SX_W-1:0]  SX_LAST  = SX_W'(SCALE - 1);
   localparam logic [IDX_W-1:0] ROW_STEP = IDX_W'(WIDTH);

   logic w_active, w_hsync, w_vsync, w_win, w_win_last;
   logic w_frame_first, w_frame_last, w_en;

   video_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
      .SYNC_POL (SYNC_POL), .X_OFS (X_OFS), .Y_OFS (Y_OFS),
      .WIN_W    (WIDTH * SCALE), .WIN_H (HEIGHT * SCALE)
   ) u_timing (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .o_active      (w_active),
      .o_hsync       (w_hsync),
      .o_vsync       (w_vsync),
      .o_win         (w_win),
      .o_win_last    (w_win_last),
      .o_frame_first (w_frame_first),
      .o_frame_last  (w_frame_last)
   );

   logic             r_en_q;
   logic [SX_W-1:0]  r_sx, r_sy;
   logic [IDX_W-1:0] r_px, r_row_base;
   logic [IDX_W-1:0] w_idx;

   // The frame-start cycle itself already obeys the freshly sampled enable.
   assign w_en  = w_frame_first ? i_en : r_en_q;
   assign w_idx = r_row_base + r_px;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_en_q <= 1'b0;
      end else if (w_frame_first) begin
         r_en_q <= i_en;
      end
   end

   // Incremental pixel stepping; cleared in the last blanking cycle of a frame.
   always_ff @(posedge i_clk) begin
      if (i_rst || w_frame_last) begin
         r_sx       <= '0;
         r_sy       <= '0;
         r_px       <= '0;
         r_row_base <= '0;
      end else if (w_win) begin
         if (w_win_last) begin
            r_sx <= '0;
            r_px <= '0;
            if (r_sy == SX_LAST) begin
               r_sy       <= '0;
               r_row_base <= r_row_base + ROW_STEP;
            end else begin
               r_sy <= r_sy + 1'b1;
            end
         end else if (r_sx == SX_LAST) begin
            r_sx <= '0;
            r_px <= r_px + 1'b1;
         end else begin
            r_sx <= r_sx + 1'b1;
         end
      end
   end

   rgb_t r_pal [16];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < 16; i++) begin
            r_pal[i] <= DEFAULT_PALETTE[i];
         end
      end else if (i_pal_we) begin
         r_pal[i_pal_idx] <= i_pal_rgb;
      end
   end

   logic              r_mev;
   logic [ADDR_W-1:0] r_adrv;
   logic              r_sel1, r_fetch2, r_sel2;
   logic [2:0]        r_hs_pipe, r_vs_pipe, r_de_pipe, r_fs_pipe;
   rgb_t              r_rgb;
   logic [3:0]        w_nib;

   assign w_nib = r_sel2 ? vram.qv[7:4] : vram.qv[3:0];

   // Fetch at T+1, VRAM data at T+2, colour at T+3; flags ride a 3-deep shift.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mev     <= 1'b0;
         r_adrv    <= '0;
         r_sel1    <= 1'b0;
         r_fetch2  <= 1'b0;
         r_sel2    <= 1'b0;
         r_rgb     <= '0;
         r_hs_pipe <= {3{~SYNC_POL}};
         r_vs_pipe <= {3{~SYNC_POL}};
         r_de_pipe <= '0;
         r_fs_pipe <= '0;
      end else begin
         r_mev     <= w_win && w_en;
         r_adrv    <= w_idx[IDX_W-1:1];
         r_sel1    <= w_idx[0];
         r_fetch2  <= r_mev;
         r_sel2    <= r_sel1;
         r_rgb     <= r_fetch2 ? r_pal[w_nib] : '0;
         r_hs_pipe <= {r_hs_pipe[1:0], w_hsync};
         r_vs_pipe <= {r_vs_pipe[1:0], w_vsync};
         r_de_pipe <= {r_de_pipe[1:0], w_active};
         r_fs_pipe <= {r_fs_pipe[1:0], w_frame_first};
      end
   end

   assign vram.mev      = r_mev;
   assign vram.adrv     = r_adrv;
   assign o_hsync       = r_hs_pipe[2];
   assign o_vsync       = r_vs_pipe[2];
   assign o_de          = r_de_pipe[2];
   assign o_frame_start = r_fs_pipe[2];
   assign o_r           = r_rgb.r;
   assign o_g           = r_rgb.g;
   assign o_b           = r_rgb.b;

endmodule
